// File: rtl/mc_control_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM, 3+ cycles per instruction, stalls on imem_ready/dmem_ready.
// Optional ILLEGAL_HALT_EN: unknown opcode parks the FSM in HALT (adds port halted) instead of retiring as a NOP.
module mc_control_sequencer #(
    parameter int DMEM_TIMEOUT = 255,
    parameter int INSTRET_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    input  logic [31:0]          Instr,
    input  logic                 BrEq,
    input  logic                 BrLT,
    output logic                 imem_req,
    output logic                 ir_we,
    output logic                 dmem_req,
    output logic                 MemWrite,
    output logic                 pc_we,
    output logic                 PCSrc,
    output logic [1:0]           ResultSrc,
    output logic                 ALUSrc,
    output logic [1:0]           ImmSrc,
    output logic [2:0]           ALUControl,
    output logic                 RegWrite,
    output logic                 bus_err,
`ifdef ILLEGAL_HALT_EN
    output logic                 halted,
`endif
    output logic [INSTRET_W-1:0] instret
);

    localparam int CNT_W = (DMEM_TIMEOUT < 2) ? 1 : $clog2(DMEM_TIMEOUT + 1);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
`ifdef ILLEGAL_HALT_EN
        S_HALT,
`endif
        S_MEM
    } state_t;

    state_t                 state_q, state_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;
    logic                   bus_err_q, bus_err_d;
    logic [CNT_W-1:0]       tmo_q, tmo_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_r, is_i, is_ld, is_st, is_br, is_jal;
    logic [2:0] dec_alu;
    logic [1:0] dec_imm;
    logic       dec_alusrc;
    logic       br_taken;
    logic [CNT_W:0] tmo_inc;
    logic       tmo_hit;

    assign opcode = Instr[6:0];
    assign funct3 = Instr[14:12];
    assign is_r   = (opcode == OP_R);
    assign is_i   = (opcode == OP_I);
    assign is_ld  = (opcode == OP_LW);
    assign is_st  = (opcode == OP_SW);
    assign is_br  = (opcode == OP_BR);
    assign is_jal = (opcode == OP_JAL);

    // ready in the same cycle as the limit wins, since dmem_ready is checked first below
    assign tmo_inc = {1'b0, tmo_q} + 1'b1;
    assign tmo_hit = (DMEM_TIMEOUT != 0) && (tmo_inc == (CNT_W + 1)'(DMEM_TIMEOUT));

    always_comb begin
        dec_alu    = 3'b000;
        dec_imm    = 2'b00;
        dec_alusrc = is_i | is_ld | is_st;
        br_taken   = 1'b0;
        if (is_br) begin
            dec_alu = 3'b001;
            dec_imm = 2'b10;
        end else if (is_r || is_i) begin
            case (funct3)
                3'b000:  dec_alu = (is_r && Instr[30]) ? 3'b001 : 3'b000;
                3'b010:  dec_alu = 3'b101;
                3'b110:  dec_alu = 3'b011;
                3'b111:  dec_alu = 3'b010;
                default: dec_alu = 3'b000;
            endcase
        end else if (is_st) begin
            dec_imm = 2'b01;
        end else if (is_jal) begin
            dec_imm = 2'b11;
        end
        case (funct3)
            3'b000:  br_taken = BrEq;
            3'b001:  br_taken = ~BrEq;
            3'b100:  br_taken = BrLT;
            3'b101:  br_taken = ~BrLT;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        instret_d  = instret_q;
        bus_err_d  = bus_err_q;
        tmo_d      = '0;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        dmem_req   = 1'b0;
        MemWrite   = 1'b0;
        pc_we      = 1'b0;
        PCSrc      = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrc     = 1'b0;
        ImmSrc     = 2'b00;
        ALUControl = 3'b000;
        RegWrite   = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrc     = dec_alusrc;
                ImmSrc     = dec_imm;
                ALUControl = dec_alu;
                state_d    = S_EXEC;
            end
            S_EXEC: begin
                ALUSrc     = dec_alusrc;
                ImmSrc     = dec_imm;
                ALUControl = dec_alu;
                state_d    = S_FETCH;
                if (is_ld || is_st) begin
                    state_d = S_MEM;
                end else if (is_r || is_i || is_br || is_jal) begin
                    pc_we     = 1'b1;
                    instret_d = instret_q + 1'b1;
                    RegWrite  = is_r | is_i | is_jal;
                    ResultSrc = is_jal ? 2'b10 : 2'b00;
                    PCSrc     = is_jal | (is_br & br_taken);
                end else begin
`ifdef ILLEGAL_HALT_EN
                    state_d   = S_HALT;
`else
                    pc_we     = 1'b1;
                    instret_d = instret_q + 1'b1;
`endif
                end
            end
            S_MEM: begin
                ALUSrc     = dec_alusrc;
                ImmSrc     = dec_imm;
                ALUControl = dec_alu;
                dmem_req   = 1'b1;
                MemWrite   = is_st;
                if (dmem_ready) begin
                    RegWrite  = is_ld;
                    ResultSrc = is_ld ? 2'b01 : 2'b00;
                    pc_we     = 1'b1;
                    instret_d = instret_q + 1'b1;
                    state_d   = S_FETCH;
                end else if (tmo_hit) begin
                    // skip the faulting access: advance PC without retiring it
                    bus_err_d = 1'b1;
                    pc_we     = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    tmo_d = tmo_inc[CNT_W-1:0];
                end
            end
            default: state_d = state_q;
        endcase
        if (reset) begin
            imem_req   = 1'b0;
            ir_we      = 1'b0;
            dmem_req   = 1'b0;
            MemWrite   = 1'b0;
            pc_we      = 1'b0;
            PCSrc      = 1'b0;
            ResultSrc  = 2'b00;
            ALUSrc     = 1'b0;
            ImmSrc     = 2'b00;
            ALUControl = 3'b000;
            RegWrite   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            bus_err_q <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            bus_err_q <= bus_err_d;
            tmo_q     <= tmo_d;
        end
    end

    assign bus_err = bus_err_q;
    assign instret = instret_q;
`ifdef ILLEGAL_HALT_EN
    assign halted  = (state_q == S_HALT);
`endif

endmodule

// File: tb/tb_mc_control_sequencer.sv
// Directed bench for mc_control_sequencer: stimulus pushes expected retire records, a monitor checks each pc_we pulse.
module tb_mc_control_sequencer;

    logic        clk, reset, imem_ready, dmem_ready, BrEq, BrLT;
    logic [31:0] Instr;
    logic        imem_req, ir_we, dmem_req, MemWrite, pc_we, PCSrc, ALUSrc, RegWrite, bus_err;
    logic [1:0]  ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;
    logic [31:0] instret;
`ifdef ILLEGAL_HALT_EN
    logic        halted;
`endif

    mc_control_sequencer #(.DMEM_TIMEOUT(4), .INSTRET_W(32)) dut (
        .clk(clk), .reset(reset), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .Instr(Instr), .BrEq(BrEq), .BrLT(BrLT),
        .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .MemWrite(MemWrite),
        .pc_we(pc_we), .PCSrc(PCSrc), .ResultSrc(ResultSrc), .ALUSrc(ALUSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .RegWrite(RegWrite), .bus_err(bus_err),
`ifdef ILLEGAL_HALT_EN
        .halted(halted),
`endif
        .instret(instret)
    );

    typedef struct packed {
        logic        pcsrc;
        logic        rw;
        logic [1:0]  rsrc;
        logic [1:0]  imm;
        logic        alusrc;
        logic [2:0]  aluc;
        logic        memw;
        logic        berr;
        logic [31:0] iret;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic pcsrc, input logic rw, input logic [1:0] rsrc,
                                input logic [1:0] imm, input logic alusrc, input logic [2:0] aluc,
                                input logic memw, input logic berr, input int iret);
        exp_t e;
        e = '{pcsrc, rw, rsrc, imm, alusrc, aluc, memw, berr, iret};
        return e;
    endfunction

    exp_t mon_e, mon_a;
    always @(negedge clk) begin
        if (!reset) begin
            if (pc_we) begin
                chk("pc_we_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    mon_a = {PCSrc, RegWrite, ResultSrc, ImmSrc, ALUSrc, ALUControl, MemWrite, bus_err, instret};
                    chk("retire", mon_a, mon_e);
                end
            end
            if (RegWrite) chk("regwrite_with_pc_we", pc_we, 1'b1);
        end
    end

    task automatic do_instr(input logic [31:0] ins, input int iwait, input int mwait,
                            input logic beq_i, input logic blt_i, input exp_t e, input int mem_cyc);
        int cyc;
        bit done;
        exp_q.push_back(e);
        BrEq = beq_i;
        BrLT = blt_i;
        for (int k = 0; k < iwait; k++) begin
            @(negedge clk);
            chk("fetch_wait", {imem_req, ir_we}, 2'b10);
            @(posedge clk); #1;
        end
        Instr = ins;
        imem_ready = 1'b1;
        @(negedge clk);
        chk("fetch_load", {imem_req, ir_we}, 2'b11);
        @(posedge clk); #1;
        imem_ready = 1'b0;
        @(negedge clk);
        chk("decode", {pc_we, RegWrite, dmem_req, imem_req, ImmSrc, ALUSrc, ALUControl},
            {4'b0000, e.imm, e.alusrc, e.aluc});
        @(posedge clk); #1;
        if (mem_cyc > 0) begin
            @(posedge clk); #1;
            cyc = 0;
            done = 1'b0;
            for (int g = 0; g < 50 && !done; g++) begin
                dmem_ready = (mwait >= 0) && (cyc == mwait);
                @(negedge clk);
                if (dmem_req) cyc++;
                else done = 1'b1;
                @(posedge clk); #1;
            end
            dmem_ready = 1'b0;
            chk("dmem_req_cycles", cyc, mem_cyc);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
        BrEq = 1'b0; BrLT = 1'b0; Instr = 32'h0;
        #3;
        chk("reset_outputs", {imem_req, ir_we, dmem_req, MemWrite, pc_we, PCSrc, ResultSrc, ALUSrc,
                              ImmSrc, ALUControl, RegWrite, bus_err, instret}, 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset", {imem_req, bus_err, instret}, {1'b1, 1'b0, 32'd0});
        @(posedge clk); #1;

        //       ins           iw mw  eq    lt    pc  rw rsrc   imm    as  aluc    mw  be  iret   memcyc
        do_instr(32'h00500093, 2, 0, 1'b0, 1'b0, mk(0, 1, 2'b00, 2'b00, 1, 3'b000, 0, 0, 0),  0); // addi
        do_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, mk(0, 1, 2'b00, 2'b00, 0, 3'b000, 0, 0, 1),  0); // add
        do_instr(32'h402081B3, 1, 0, 1'b0, 1'b0, mk(0, 1, 2'b00, 2'b00, 0, 3'b001, 0, 0, 2),  0); // sub
        do_instr(32'h00502093, 0, 0, 1'b0, 1'b0, mk(0, 1, 2'b00, 2'b00, 1, 3'b101, 0, 0, 3),  0); // slti
        do_instr(32'h0020F1B3, 0, 0, 1'b0, 1'b0, mk(0, 1, 2'b00, 2'b00, 0, 3'b010, 0, 0, 4),  0); // and
        do_instr(32'h00506093, 0, 0, 1'b0, 1'b0, mk(0, 1, 2'b00, 2'b00, 1, 3'b011, 0, 0, 5),  0); // ori
        do_instr(32'h00208463, 0, 0, 1'b1, 1'b0, mk(1, 0, 2'b00, 2'b10, 0, 3'b001, 0, 0, 6),  0); // beq taken
        do_instr(32'h00209463, 0, 0, 1'b1, 1'b0, mk(0, 0, 2'b00, 2'b10, 0, 3'b001, 0, 0, 7),  0); // bne not taken
        do_instr(32'h0020C463, 0, 0, 1'b0, 1'b1, mk(1, 0, 2'b00, 2'b10, 0, 3'b001, 0, 0, 8),  0); // blt taken
        do_instr(32'h0020D463, 0, 0, 1'b0, 1'b1, mk(0, 0, 2'b00, 2'b10, 0, 3'b001, 0, 0, 9),  0); // bge not taken
        do_instr(32'h010000EF, 0, 0, 1'b0, 1'b0, mk(1, 1, 2'b10, 2'b11, 0, 3'b000, 0, 0, 10), 0); // jal
        do_instr(32'h0000A103, 0, 3, 1'b0, 1'b0, mk(0, 1, 2'b01, 2'b00, 1, 3'b000, 0, 0, 11), 4); // lw, ready on 4th MEM cycle
        do_instr(32'h0020A023, 0, -1, 1'b0, 1'b0, mk(0, 0, 2'b00, 2'b01, 1, 3'b000, 1, 0, 12), 4); // sw timeout
        chk("bus_err_set", bus_err, 1'b1);
        chk("instret_after_timeout", instret, 32'd12);
        do_instr(32'h00500093, 0, 0, 1'b0, 1'b0, mk(0, 1, 2'b00, 2'b00, 1, 3'b000, 0, 1, 12), 0); // bus_err sticky

        // reset in the middle of a load's MEM phase
        Instr = 32'h0000A103;
        imem_ready = 1'b1;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("lw_mem_req", {dmem_req, ALUSrc}, 2'b11);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_outputs", {imem_req, ir_we, dmem_req, MemWrite, pc_we, PCSrc, ResultSrc, ALUSrc,
                                    ImmSrc, ALUControl, RegWrite, bus_err, instret}, 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_release", {imem_req, RegWrite, dmem_req, bus_err, instret}, {4'b1000, 32'd0});
        @(posedge clk); #1;
        do_instr(32'h00500093, 0, 0, 1'b0, 1'b0, mk(0, 1, 2'b00, 2'b00, 1, 3'b000, 0, 0, 0), 0);

`ifdef ILLEGAL_HALT_EN
        Instr = 32'h0000007F;
        imem_ready = 1'b1;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("halt_hold", {halted, imem_req, pc_we, RegWrite}, 4'b1000);
        end
        chk("instret_final", instret, 32'd1);
`else
        do_instr(32'h0000007F, 0, 0, 1'b0, 1'b0, mk(0, 0, 2'b00, 2'b00, 0, 3'b000, 0, 0, 1), 0); // unknown -> NOP
        @(negedge clk);
        chk("instret_final", instret, 32'd2);
`endif
        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
